// File: rtl/fp16_accum_sequencer.sv
// fp16_accum_sequencer: drives a fixed-latency sequential FP16 adder one
// operation at a time, folding a valid/ready element stream into one
// accumulated sum per packet.
// Optional build macro ACC_BYPASS_FIRST_EN: the first element of a packet is
// loaded straight into the accumulator instead of being added to +0.
module fp16_accum_sequencer #(
  parameter int unsigned ADD_LATENCY = 4,
  parameter int unsigned COUNT_W     = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [15:0]        in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               sum_valid,
  output logic [15:0]        sum_data,
  output logic               sum_overflow,
  output logic               sum_underflow,
  output logic [COUNT_W-1:0] sum_count,
  input  logic               sum_ready,
  output logic               add_clk_en,
  output logic [15:0]        add_dataa,
  output logic [15:0]        add_datab,
  input  logic [15:0]        add_result,
  input  logic               add_overflow,
  input  logic               add_underflow
);

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [3:0] LAT    = 4'(ADD_LATENCY);
  localparam logic [3:0] LAT_M1 = 4'(ADD_LATENCY - 1);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [15:0]        r_acc;
  logic               r_ovf;
  logic               r_unf;
  logic [COUNT_W-1:0] r_count;
  logic               r_last;
  logic               r_in_ready;
  logic               r_sum_valid;
  logic               r_add_clk_en;
  logic [15:0]        r_dataa;
  logic [15:0]        r_datab;

  logic               w_accept;
  logic               w_bypass;
  logic [COUNT_W-1:0] w_count_inc;

  assign w_accept    = in_valid & r_in_ready;
  assign w_count_inc = (r_count == '1) ? r_count : r_count + COUNT_W'(1);

`ifdef ACC_BYPASS_FIRST_EN
  // An empty count marks the first element of a packet.
  assign w_bypass = (r_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign in_ready      = r_in_ready;
  assign sum_valid     = r_sum_valid;
  assign sum_data      = r_acc;
  assign sum_overflow  = r_ovf;
  assign sum_underflow = r_unf;
  assign sum_count     = r_count;
  assign add_clk_en    = r_add_clk_en;
  assign add_dataa     = r_dataa;
  assign add_datab     = r_datab;

  // Sequencer FSM: drain, accept, issue one add, wait out latency, present sum.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= S_DRAIN;
      r_cnt        <= LAT;
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_count      <= '0;
      r_last       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_sum_valid  <= 1'b0;
      r_add_clk_en <= 1'b0;
      r_dataa      <= '0;
      r_datab      <= '0;
    end else begin
      case (r_state)
        S_DRAIN: begin
          // The adder has no reset; let any operation in flight run out.
          if (r_cnt == 4'd1) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_count <= w_count_inc;
            if (w_bypass) begin
              r_acc <= in_data;
              if (in_last) begin
                r_in_ready  <= 1'b0;
                r_sum_valid <= 1'b1;
                r_state     <= S_OUT;
              end
            end else begin
              r_dataa      <= r_acc;
              r_datab      <= in_data;
              r_last       <= in_last;
              r_in_ready   <= 1'b0;
              r_add_clk_en <= 1'b1;
              r_state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_add_clk_en <= 1'b0;
          r_cnt        <= LAT_M1;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_acc <= add_result;
            r_ovf <= r_ovf | add_overflow;
            r_unf <= r_unf | add_underflow;
            if (r_last) begin
              r_sum_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_OUT: begin
          if (sum_ready) begin
            r_sum_valid <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_DRAIN;
          r_cnt   <= LAT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_accum_sequencer.sv
// Bench for fp16_accum_sequencer: a latency-accurate FP16 adder model feeds
// add_result, and packet sums are predicted from real-valued FP16 arithmetic.
module tb_fp16_accum_sequencer;

  localparam int unsigned L  = 4;
  localparam int unsigned CW = 8;
`ifdef ACC_BYPASS_FIRST_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_last;
  logic          in_ready;
  logic          sum_valid;
  logic [15:0]   sum_data;
  logic          sum_overflow;
  logic          sum_underflow;
  logic [CW-1:0] sum_count;
  logic          sum_ready;
  logic          add_clk_en;
  logic [15:0]   add_dataa;
  logic [15:0]   add_datab;
  logic [15:0]   add_result;
  logic          add_overflow;
  logic          add_underflow;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fp16_accum_sequencer #(.ADD_LATENCY(L), .COUNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .sum_valid(sum_valid), .sum_data(sum_data), .sum_overflow(sum_overflow),
    .sum_underflow(sum_underflow), .sum_count(sum_count), .sum_ready(sum_ready),
    .add_clk_en(add_clk_en), .add_dataa(add_dataa), .add_datab(add_datab),
    .add_result(add_result), .add_overflow(add_overflow), .add_underflow(add_underflow)
  );

  // ---------------- FP16 arithmetic via reals ----------------
  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    int e = int'(h[14:10]);
    int m = int'(h[9:0]);
    if (e == 0) v = real'(m) * pow2(-24);
    else        v = real'(1024 + m) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  // Returns {underflow, overflow, fp16} with round-to-nearest-even.
  function automatic logic [17:0] r2h(input real v);
    logic s;
    real a, frac, rem;
    int e, f;
    if (v == 0.0) return 18'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    if (e < -14) return {1'b1, 1'b0, s, 15'h0};
    frac = (a - 1.0) * 1024.0;
    f = $rtoi(frac);
    rem = frac - real'(f);
    if (rem > 0.5 || (rem == 0.5 && (f % 2) == 1)) f++;
    if (f == 1024) begin f = 0; e++; end
    if (e > 15) return {1'b0, 1'b1, s, 5'h1f, 10'h0};
    return {2'b00, s, 5'(e + 15), 10'(f)};
  endfunction

  function automatic logic [17:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic ai = (a[14:10] == 5'h1f);
    logic bi = (b[14:10] == 5'h1f);
    if (ai && bi && (a[15] != b[15])) return {2'b00, 16'h7e00};
    if (ai) return {2'b00, a};
    if (bi) return {2'b00, b};
    return r2h(h2r(a) + h2r(b));
  endfunction

  function automatic logic [15:0] i2h(input int v);
    logic [17:0] r = r2h(real'(v));
    return r[15:0];
  endfunction

  // Expected {underflow, overflow, sum} for a packet.
  function automatic logic [17:0] ref_sum(input logic [15:0] q[$]);
    logic [15:0] acc = 16'h0;
    logic ov = 1'b0, uf = 1'b0;
    logic [17:0] r;
    foreach (q[i]) begin
      if (i == 0 && BYPASS) acc = q[0];
      else begin
        r = fp_add(acc, q[i]);
        acc = r[15:0]; ov = ov | r[16]; uf = uf | r[17];
      end
    end
    return {uf, ov, acc};
  endfunction

  // ---------------- adder model: result valid only for its sampling edge ----------------
  logic        m_busy = 1'b0;
  int unsigned m_cd   = 0;
  logic [15:0] m_a, m_b;

  always @(posedge clock) begin
    if (m_busy && m_cd == 1) {add_underflow, add_overflow, add_result} <= fp_add(m_a, m_b);
    else begin
      add_result    <= 16'($urandom);
      add_overflow  <= 1'($urandom_range(0, 1));
      add_underflow <= 1'($urandom_range(0, 1));
    end
    if (add_clk_en) begin
      m_busy <= 1'b1; m_cd <= L - 1; m_a <= add_dataa; m_b <= add_datab;
    end else if (m_busy) begin
      m_cd <= m_cd - 1;
      if (m_cd == 1) m_busy <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int unsigned cyc = 0, pulses = 0, accepts = 0, stab_err = 0;
  int unsigned pulse_at [0:4095];
  logic [15:0] last_pa = 16'h0, last_pb = 16'h0;
  logic        c_ok = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) accepts <= accepts + 1;
    if (add_clk_en) begin
      pulse_at[pulses[11:0]] <= cyc;
      pulses  <= pulses + 1;
      last_pa <= add_dataa;
      last_pb <= add_datab;
    end
    if (!reset_n) c_ok <= 1'b0;
    else if (add_clk_en) c_ok <= 1'b1;
    if (reset_n && c_ok && m_busy && !add_clk_en && (add_dataa != m_a || add_datab != m_b))
      stab_err <= stab_err + 1;
  end

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic send(input logic [15:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 200) begin @(negedge clock); n++; end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic collect(output logic [15:0] d, output logic ov, output logic uf,
                         output logic [CW-1:0] c);
    int n = 0;
    while (!sum_valid && n < 2000) begin @(negedge clock); n++; end
    total++;
    if (!sum_valid) begin
      bad++;
      $display("FAIL sum_timeout sum_valid=%0b required 1", sum_valid);
      d = 16'hxxxx; ov = 1'bx; uf = 1'bx; c = 'x;
      return;
    end
    d = sum_data; ov = sum_overflow; uf = sum_underflow; c = sum_count;
    sum_ready = 1'b1;
    @(negedge clock);
    sum_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    int n = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; sum_ready = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({in_ready, sum_valid, add_clk_en, sum_overflow, sum_underflow} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got %b required 00000",
               {in_ready, sum_valid, add_clk_en, sum_overflow, sum_underflow});
    end
    total++;
    if ({sum_data, sum_count, add_dataa, add_datab} !== '0) begin
      bad++;
      $display("FAIL reset_data got sum=%h cnt=%h a=%h b=%h required zeros",
               sum_data, sum_count, add_dataa, add_datab);
    end
    reset_n = 1'b1;
    while (!in_ready && n < 40) begin @(negedge clock); n++; end
    total++;
    if (n != L) begin bad++; $display("FAIL reset_drain got %0d cycles required %0d", n, L); end
  endtask

  task automatic test_pair;
    logic [15:0] d; logic ov, uf; logic [CW-1:0] c;
    int unsigned p0 = pulses;
    send(16'h3c00, 1'b0);
    send(16'h4000, 1'b1);
    collect(d, ov, uf, c);
    total++;
    if (d !== 16'h4200) begin bad++; $display("FAIL pair_sum got %h required 4200", d); end
    total++;
    if (c !== CW'(2) || {ov, uf} !== 2'b00) begin
      bad++; $display("FAIL pair_cnt_flags got cnt=%0d ov=%b uf=%b required 2 0 0", c, ov, uf);
    end
    total++;
    if (pulses - p0 != (BYPASS ? 1 : 2)) begin
      bad++; $display("FAIL pair_pulses got %0d required %0d", pulses - p0, BYPASS ? 1 : 2);
    end
    total++;
    if (sum_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL pair_release got sv=%b ir=%b required 0 1", sum_valid, in_ready);
    end
  endtask

  task automatic test_single;
    logic [15:0] d; logic ov, uf; logic [CW-1:0] c;
    int unsigned p0 = pulses;
    int k = 0;
    send(16'h4000, 1'b1);
    while (!sum_valid && k < 100) begin @(negedge clock); k++; end
    total++;
    if (k != (BYPASS ? 0 : int'(L) + 1)) begin
      bad++; $display("FAIL single_latency got %0d edges required %0d", k, BYPASS ? 0 : L + 1);
    end
    collect(d, ov, uf, c);
    total++;
    if (d !== 16'h4000 || c !== CW'(1)) begin
      bad++; $display("FAIL single_sum got %h cnt=%0d required 4000 1", d, c);
    end
    total++;
    if (pulses - p0 != (BYPASS ? 0 : 1)) begin
      bad++; $display("FAIL single_pulses got %0d required %0d", pulses - p0, BYPASS ? 0 : 1);
    end
`ifndef ACC_BYPASS_FIRST_EN
    total++;
    if (last_pa !== 16'h0000 || last_pb !== 16'h4000) begin
      bad++; $display("FAIL single_operands got a=%h b=%h required 0000 4000", last_pa, last_pb);
    end
`endif
  endtask

  task automatic test_backpressure;
    logic [15:0] d0;
    int unsigned p0, a0;
    int n = 0;
    send(16'h3c00, 1'b1);
    while (!sum_valid && n < 100) begin @(negedge clock); n++; end
    d0 = sum_data;
    total++;
    if (sum_valid !== 1'b1 || d0 !== 16'h3c00) begin
      bad++; $display("FAIL bp_first got sv=%b sum=%h required 1 3c00", sum_valid, d0);
    end
    p0 = pulses; a0 = accepts;
    in_valid = 1'b1; in_data = 16'h4000; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if (sum_valid !== 1'b1 || sum_data !== d0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cycle %0d got sv=%b sum=%h ir=%b required 1 %h 0",
                        i, sum_valid, sum_data, in_ready, d0);
      end
    end
    total++;
    if (pulses != p0 || accepts != a0) begin
      bad++; $display("FAIL bp_idle got pulses+%0d accepts+%0d required 0 0", pulses - p0, accepts - a0);
    end
    sum_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clock);
    sum_ready = 1'b0;
    total++;
    if (sum_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got sv=%b ir=%b required 0 1", sum_valid, in_ready);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] d; logic ov, uf; logic [CW-1:0] c;
    logic [15:0] q[$];
    logic [17:0] e;
    q = '{16'h7bff, 16'h7bff, 16'h3c00};
    e = ref_sum(q);
    send(q[0], 1'b0); send(q[1], 1'b0); send(q[2], 1'b1);
    collect(d, ov, uf, c);
    total++;
    if (d !== e[15:0] || {uf, ov} !== e[17:16] || ov !== 1'b1 || c !== CW'(3)) begin
      bad++; $display("FAIL ovf_pkt got sum=%h ov=%b uf=%b cnt=%0d required %h %b %b 3",
                      d, ov, uf, c, e[15:0], e[16], e[17]);
    end
    send(16'h3c00, 1'b1);
    collect(d, ov, uf, c);
    total++;
    if (d !== 16'h3c00 || {ov, uf} !== 2'b00 || c !== CW'(1)) begin
      bad++; $display("FAIL ovf_clear got sum=%h ov=%b uf=%b cnt=%0d required 3c00 0 0 1", d, ov, uf, c);
    end
  endtask

  task automatic test_reset_wait;
    logic [15:0] d; logic ov, uf; logic [CW-1:0] c;
    int n = 0;
    logic sv_seen = 1'b0;
    send(16'h3c00, 1'b0);
    send(16'h3c00, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    while (!in_ready && n < 40) begin
      if (sum_valid) sv_seen = 1'b1;
      @(negedge clock); n++;
    end
    total++;
    if (n != L) begin bad++; $display("FAIL rstwait_drain got %0d cycles required %0d", n, L); end
    total++;
    if (sv_seen || sum_valid) begin bad++; $display("FAIL rstwait_nosum got sum_valid=1 required 0"); end
    send(16'h4200, 1'b1);
    collect(d, ov, uf, c);
    total++;
    if (d !== 16'h4200 || c !== CW'(1) || {ov, uf} !== 2'b00) begin
      bad++; $display("FAIL rstwait_next got sum=%h cnt=%0d ov=%b uf=%b required 4200 1 0 0", d, c, ov, uf);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d; logic ov, uf; logic [CW-1:0] c;
    int unsigned p0 = pulses, a0 = accepts, np;
    int n;
    in_valid = 1'b1; in_data = 16'h3c00;
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 3);
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clock); n++; end
      @(posedge clock);
      @(negedge clock);
    end
    in_valid = 1'b0; in_last = 1'b0;
    collect(d, ov, uf, c);
    total++;
    if (d !== 16'h4400 || c !== CW'(4)) begin
      bad++; $display("FAIL b2b_sum got %h cnt=%0d required 4400 4", d, c);
    end
    total++;
    if (accepts - a0 != 4) begin bad++; $display("FAIL b2b_accepts got %0d required 4", accepts - a0); end
    np = pulses - p0;
    total++;
    if (np != (BYPASS ? 3 : 4)) begin bad++; $display("FAIL b2b_pulses got %0d required %0d", np, BYPASS ? 3 : 4); end
    for (int unsigned i = p0; i + 1 < pulses; i++) begin
      total++;
      if (pulse_at[(i + 1) % 4096] - pulse_at[i % 4096] < L + 2) begin
        bad++; $display("FAIL b2b_spacing got %0d required >=%0d",
                        pulse_at[(i + 1) % 4096] - pulse_at[i % 4096], L + 2);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] d; logic ov, uf; logic [CW-1:0] c;
    logic [15:0] q[$];
    logic [17:0] e;
    int len;
    int unsigned p0;
    for (int p = 0; p < 12; p++) begin
      q.delete();
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) q.push_back(i2h(int'($urandom_range(0, 16)) - 8));
      e = ref_sum(q);
      p0 = pulses;
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        send(q[i], i == len - 1);
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      collect(d, ov, uf, c);
      total++;
      if (d !== e[15:0] || {uf, ov} !== e[17:16] || c !== CW'(len)) begin
        bad++; $display("FAIL rand_pkt%0d got sum=%h ov=%b uf=%b cnt=%0d required %h %b %b %0d",
                        p, d, ov, uf, c, e[15:0], e[16], e[17], len);
      end
      total++;
      if (pulses - p0 != unsigned'(len - (BYPASS ? 1 : 0))) begin
        bad++; $display("FAIL rand_pulses%0d got %0d required %0d", p, pulses - p0, len - (BYPASS ? 1 : 0));
      end
    end
    total++;
    if (stab_err != 0) begin bad++; $display("FAIL operand_stability got %0d changes required 0", stab_err); end
  endtask

  task automatic test_saturation;
    logic [15:0] d; logic ov, uf; logic [CW-1:0] c;
    logic [15:0] q[$];
    logic [17:0] e;
    for (int i = 0; i < 257; i++) q.push_back(16'h3c00);
    e = ref_sum(q);
    for (int i = 0; i < 257; i++) send(16'h3c00, i == 256);
    collect(d, ov, uf, c);
    total++;
    if (c !== '1) begin bad++; $display("FAIL sat_count got %0d required %0d", c, 2 ** CW - 1); end
    total++;
    if (d !== e[15:0]) begin bad++; $display("FAIL sat_sum got %h required %h", d, e[15:0]); end
  endtask

  initial begin
    test_reset;
    test_pair;
    test_single;
    test_backpressure;
    test_overflow;
    test_reset_wait;
    test_back_to_back;
    test_random;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
